// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared constants and types for the MLP result collector
package mlp_pkg;
  localparam int DATA_W          = 32;
  localparam int BEATS_PER_ROW   = 8;
  localparam int BEATS_PER_FRAME = 128;
  localparam int ADDR_W          = 7;

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_e;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
  } result_beat_t;
endpackage

// File: rtl/result_buf.sv
// rtl/result_buf.sv - simple dual-port frame buffer, one write port and one registered read port
module result_buf #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/mlp_result_collector.sv
// rtl/mlp_result_collector.sv - captures one result frame and replays it on a valid/ready stream with row tags
module mlp_result_collector
  import mlp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid_i,
  input  logic [DATA_W-1:0] res_payload_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic [3:0]        m_row_o,
  output logic              m_row_last_o,
  output logic              m_frame_last_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              err_overflow_o,
  input  logic              err_clr_i
);
  localparam int              ROW_BITS  = $clog2(BEATS_PER_ROW);
  localparam logic [ADDR_W:0] LAST_BEAT = (ADDR_W+1)'(BEATS_PER_FRAME - 1);
  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);

  state_e          state_q, state_d;
  logic [ADDR_W:0] wr_ptr, rd_ptr, rd_next;
  logic            valid_q, fire, last_fire, wr_en;
  result_beat_t    rd_beat;

  assign fire      = valid_q & m_ready_i;
  assign last_fire = fire && (rd_ptr == LAST_BEAT);
  assign wr_en     = res_valid_i && (state_q != DRAIN);
  // The RAM is always addressed with the beat that will be on the output next
  // cycle, so a stalled beat is simply re-read and the read register acts as
  // the output register with no bubble between accepted beats.
  assign rd_next   = rd_ptr + (fire ? PTR_ONE : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (res_valid_i) state_d = CAPTURE;
      CAPTURE: if (res_valid_i && wr_ptr == LAST_BEAT) state_d = DRAIN;
      DRAIN:   if (last_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      valid_q        <= 1'b0;
      err_overflow_o <= 1'b0;
    end else begin
      if (last_fire) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
        rd_ptr <= rd_next;
      end
      // Only already-written addresses are read, avoiding read-during-write.
      valid_q <= (state_q != IDLE) && (rd_next < wr_ptr);
      if (state_q == DRAIN && res_valid_i) err_overflow_o <= 1'b1;
      else if (err_clr_i)                  err_overflow_o <= 1'b0;
    end
  end

  result_buf #(
    .WIDTH(DATA_W),
    .DEPTH(BEATS_PER_FRAME),
    .AW   (ADDR_W)
  ) u_buf (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr[ADDR_W-1:0]),
    .wdata(res_payload_i),
    .raddr(rd_next[ADDR_W-1:0]),
    .rdata(rd_beat)
  );

  assign m_valid_o      = valid_q;
  assign m_data_o       = valid_q ? rd_beat : '0;
  assign m_row_o        = valid_q ? rd_ptr[ADDR_W-1:ROW_BITS] : '0;
  assign m_row_last_o   = valid_q && (rd_ptr[ROW_BITS-1:0] == ROW_BITS'(BEATS_PER_ROW - 1));
  assign m_frame_last_o = valid_q && (rd_ptr == LAST_BEAT);
  assign frame_done_o   = last_fire;
  assign busy_o         = (state_q != IDLE);
endmodule
